lru_eviction_policy: RTL and testbench

//  Replacement-policy stage directly downstream of the way lookup. It consumes
//  per-access hit/miss/hitWay results and keeps true-LRU age state per set.
//  On a hit it promotes the hit way to MRU. On a miss it nominates a victim way
//  and holds it until the controller commits the fill, then promotes that way.

---
 rtl/lru_eviction_policy.sv | 135 +++++++++++++
 tb/tb_lru_eviction_policy.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lru_eviction_policy.sv
// True-LRU replacement state per set: promotes hit ways to MRU, nominates a victim on
// a miss and holds it until the controller commits the fill.
module lru_eviction_policy #(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned NUM_SETS = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        accessValid,
    input  logic [$clog2(NUM_SETS)-1:0] setIndex,
    input  logic                        hit,
    input  logic                        miss,
    input  logic [NUM_WAYS-1:0]         hitWay,
    output logic                        victimValid,
    output logic [NUM_WAYS-1:0]         victimWay,
    output logic [$clog2(NUM_SETS)-1:0] victimSet,
    input  logic                        fillValid,
    output logic                        busy,
    output logic                        protoErr
);

    localparam int unsigned SET_WIDTH = $clog2(NUM_SETS);
    localparam int unsigned AGE_WIDTH = $clog2(NUM_WAYS);
    localparam logic [AGE_WIDTH-1:0] AGE_LRU = AGE_WIDTH'(NUM_WAYS - 1);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StVictim = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [AGE_WIDTH-1:0] age_q [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  victim_way_q;
    logic [AGE_WIDTH-1:0] victim_idx_q;
    logic [SET_WIDTH-1:0] victim_set_q;
    logic                 proto_err_q;

    logic                 hit_ok, miss_ok, found;
    logic [AGE_WIDTH-1:0] hit_idx, vic_idx;
    logic                 upd_en, fill_en, take_miss, proto_err_d;
    logic [SET_WIDTH-1:0] upd_set;
    logic [AGE_WIDTH-1:0] upd_way, upd_age;

    always_comb begin
        hit_ok  = hit && !miss && $onehot(hitWay);
        miss_ok = miss && !hit;

        hit_idx = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (hitWay[w]) hit_idx = AGE_WIDTH'(w);
        end

        // Prefer the lowest invalid way; fall back to the LRU way once the set is full.
        found   = 1'b0;
        vic_idx = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !valid_q[setIndex][w]) begin
                vic_idx = AGE_WIDTH'(w);
                found   = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[setIndex][w] == AGE_LRU) vic_idx = AGE_WIDTH'(w);
            end
        end

        state_d     = state_q;
        upd_en      = 1'b0;
        fill_en     = 1'b0;
        take_miss   = 1'b0;
        proto_err_d = 1'b0;
        upd_set     = setIndex;
        upd_way     = hit_idx;
        if (state_q == StIdle) begin
            if (accessValid) begin
                if (hit_ok) begin
                    upd_en = 1'b1;
                end else if (miss_ok) begin
                    take_miss = 1'b1;
                    state_d   = StVictim;
                end else begin
                    proto_err_d = 1'b1;
                end
            end
        end else if (fillValid) begin
            upd_en  = 1'b1;
            fill_en = 1'b1;
            upd_set = victim_set_q;
            upd_way = victim_idx_q;
            state_d = StIdle;
        end
        upd_age = age_q[upd_set][upd_way];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            victim_way_q <= '0;
            victim_idx_q <= '0;
            victim_set_q <= '0;
            proto_err_q  <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= AGE_WIDTH'(w);
                end
            end
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
            if (take_miss) begin
                victim_idx_q <= vic_idx;
                victim_set_q <= setIndex;
                victim_way_q <= NUM_WAYS'(1) << vic_idx;
            end
            if (fill_en) valid_q[victim_set_q][victim_idx_q] <= 1'b1;
            if (upd_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (AGE_WIDTH'(w) == upd_way) begin
                        age_q[upd_set][w] <= '0;
                    end else if (age_q[upd_set][w] < upd_age) begin
                        age_q[upd_set][w] <= age_q[upd_set][w] + 1'b1;
                    end
                end
            end
        end
    end

    assign victimValid = (state_q == StVictim);
    assign busy        = (state_q == StVictim);
    assign victimWay   = victim_way_q;
    assign victimSet   = victim_set_q;
    assign protoErr    = proto_err_q;

endmodule

// File: tb/tb_lru_eviction_policy.sv
// Directed bench for lru_eviction_policy: hand-computed victims, ages and handshake timing.
module tb_lru_eviction_policy;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       accessValid;
    logic [5:0] setIndex;
    logic       hit, miss;
    logic [3:0] hitWay;
    logic       victimValid;
    logic [3:0] victimWay;
    logic [5:0] victimSet;
    logic       fillValid;
    logic       busy;
    logic       protoErr;

    int n_vec = 0;
    int n_err = 0;

    lru_eviction_policy #(.NUM_WAYS(4), .NUM_SETS(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .accessValid (accessValid),
        .setIndex    (setIndex),
        .hit         (hit),
        .miss        (miss),
        .hitWay      (hitWay),
        .victimValid (victimValid),
        .victimWay   (victimWay),
        .victimSet   (victimSet),
        .fillValid   (fillValid),
        .busy        (busy),
        .protoErr    (protoErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ages_of(input int s);
        ages_of = {2'b0, dut.age_q[s][3], 2'b0, dut.age_q[s][2],
                   2'b0, dut.age_q[s][1], 2'b0, dut.age_q[s][0]};
    endfunction

    // Expected ages given per way 0..3; packed one nibble per way, way0 lowest.
    task automatic check_ages(input string tag, input int s,
                              input int e0, input int e1, input int e2, input int e3);
        logic [15:0] exp;
        exp = {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
        check(tag, 32'(ages_of(s)), 32'(exp));
    endtask

    task automatic access(input int s, input logic h, input logic m, input logic [3:0] hw);
        @(negedge clk);
        accessValid = 1'b1;
        setIndex    = 6'(s);
        hit         = h;
        miss        = m;
        hitWay      = hw;
        @(negedge clk);
        accessValid = 1'b0;
        hit         = 1'b0;
        miss        = 1'b0;
        hitWay      = '0;
    endtask

    task automatic fill();
        @(negedge clk);
        fillValid = 1'b1;
        @(negedge clk);
        fillValid = 1'b0;
        check("fill_busy_drop", 32'(busy), 32'(0));
        check("fill_vv_drop", 32'(victimValid), 32'(0));
    endtask

    task automatic miss_fill(input int s, input logic [3:0] exp_way);
        access(s, 1'b0, 1'b1, 4'b0);
        check("miss_vv", 32'(victimValid), 32'(1));
        check("miss_way", 32'(victimWay), 32'(exp_way));
        check("miss_set", 32'(victimSet), 32'(s));
        fill();
    endtask

    initial begin
        logic [3:0] held_way;
        int bad_sets;
        rst_n       = 1'b0;
        accessValid = 1'b0;
        setIndex    = '0;
        hit         = 1'b0;
        miss        = 1'b0;
        hitWay      = '0;
        fillValid   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vv", 32'(victimValid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_perr", 32'(protoErr), 32'(0));
        check("rst_vway", 32'(victimWay), 32'(0));
        check("rst_vset", 32'(victimSet), 32'(0));
        rst_n = 1'b1;
        check_ages("rst_ages3", 3, 0, 1, 2, 3);

        // Fill every way of set 3 through invalid-way selection.
        miss_fill(3, 4'b0001);
        check_ages("t1_ages_a", 3, 0, 1, 2, 3);
        miss_fill(3, 4'b0010);
        check_ages("t1_ages_b", 3, 1, 0, 2, 3);
        miss_fill(3, 4'b0100);
        miss_fill(3, 4'b1000);
        check_ages("t1_ages", 3, 3, 2, 1, 0);

        // Hit the LRU way, then the new LRU (way1) becomes the victim.
        access(3, 1'b1, 1'b0, 4'b0001);
        check_ages("t2_ages_hit", 3, 0, 3, 2, 1);
        check("t2_hit_busy", 32'(busy), 32'(0));
        miss_fill(3, 4'b0010);
        check_ages("t2_ages_fill", 3, 1, 0, 3, 2);

        // Held victim ignores accesses.
        access(5, 1'b0, 1'b1, 4'b0);
        held_way = victimWay;
        check("t3_way", 32'(held_way), 32'(4'b0001));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            accessValid = 1'b1;
            setIndex    = 6'd5;
            hit         = 1'b1;
            hitWay      = 4'b0010;
            check("t3_busy", 32'(busy), 32'(1));
            check("t3_vv", 32'(victimValid), 32'(1));
            check("t3_way_hold", 32'(victimWay), 32'(held_way));
            check("t3_perr", 32'(protoErr), 32'(0));
        end
        @(negedge clk);
        accessValid = 1'b0;
        hit         = 1'b0;
        hitWay      = '0;
        check_ages("t3_ages", 5, 0, 1, 2, 3);
        fill();
        check_ages("t3_ages_fill", 5, 0, 1, 2, 3);

        // Malformed accesses pulse protoErr and change nothing.
        access(5, 1'b1, 1'b1, 4'b0010);
        check("t4_perr_hm", 32'(protoErr), 32'(1));
        check("t4_busy_hm", 32'(busy), 32'(0));
        @(negedge clk);
        check("t4_perr_fall", 32'(protoErr), 32'(0));
        access(5, 1'b1, 1'b0, 4'b0011);
        check("t4_perr_oh", 32'(protoErr), 32'(1));
        @(negedge clk);
        check("t4_perr_fall2", 32'(protoErr), 32'(0));
        access(5, 1'b0, 1'b0, 4'b0000);
        check("t4_perr_none", 32'(protoErr), 32'(1));
        check_ages("t4_ages", 5, 0, 1, 2, 3);
        @(negedge clk);
        fillValid = 1'b1;
        @(negedge clk);
        fillValid = 1'b0;
        check("t4_idle_fill_perr", 32'(protoErr), 32'(0));
        check("t4_idle_fill_busy", 32'(busy), 32'(0));

        // Async reset while a victim is pending.
        access(9, 1'b0, 1'b1, 4'b0);
        check("t5_vv_pre", 32'(victimValid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_vv_rst", 32'(victimValid), 32'(0));
        check("t5_busy_rst", 32'(busy), 32'(0));
        check("t5_vway_rst", 32'(victimWay), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        check_ages("t5_ages3_rst", 3, 0, 1, 2, 3);
        miss_fill(9, 4'b0001);

        // Updates stay within the addressed set.
        miss_fill(7, 4'b0001);
        access(8, 1'b1, 1'b0, 4'b0100);
        check_ages("t6_ages8", 8, 1, 2, 0, 3);
        check_ages("t6_ages7", 7, 0, 1, 2, 3);
        access(8, 1'b1, 1'b0, 4'b0100);
        check_ages("t6_mru_noop", 8, 1, 2, 0, 3);
        access(8, 1'b1, 1'b0, 4'b1000);
        check_ages("t6_ages8_b", 8, 2, 3, 1, 0);
        bad_sets = 0;
        for (int s = 0; s < 64; s++) begin
            logic [3:0] seen;
            seen = '0;
            for (int w = 0; w < 4; w++) seen[dut.age_q[s][w]] = 1'b1;
            if (seen != 4'b1111) bad_sets++;
        end
        check("t6_perm", 32'(bad_sets), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
